// File: rtl/rom_pkg.sv
// rom_pkg: shared definitions for the ROM arbiter slice.
//   state_t          - transaction FSM states (IDLE, ACCESS, RESP)
//   REQ_FETCH/LOAD   - requester ids (bit index into the 2-bit request vectors)
//   *_DEF            - default width/size parameters
package rom_pkg;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int WORDS_DEF      = 5;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_LOAD  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;
endpackage

// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: request/response bus between the two requesters and the arbiter.
//   req_valid_i/req_addr_i/req_ready_o - per-requester request handshake (bit 0 fetch, bit 1 load)
//   rsp_valid_o/rsp_ready_i            - per-requester response handshake
//   rsp_data_o/rsp_err_o               - shared response word and out-of-range flag
// slave modport: the arbiter; master modport: the requester side.
interface rom_arbiter_if
  import rom_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic [1:0]                 req_valid_i;
  logic [1:0][ADDR_WIDTH-1:0] req_addr_i;
  logic [1:0]                 req_ready_o;
  logic [1:0]                 rsp_valid_o;
  logic [DATA_WIDTH-1:0]      rsp_data_o;
  logic                       rsp_err_o;
  logic [1:0]                 rsp_ready_i;

  modport slave (
    input  req_valid_i, req_addr_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_addr_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
  );
endinterface

// File: rtl/rom_rr_arbiter.sv
// rom_rr_arbiter: 2-way grant decision.
//   clk_i, rst_i - clock, async active-high reset
//   req          - requests eligible this cycle (already masked to IDLE by the caller)
//   accept       - a grant is being taken this cycle; updates the last-grant record
//   gnt          - one-hot grant
// Macro ROM_ARB_FIXED_PRIO_EN: requester 0 always wins ties (no last-grant state).
// Default: round-robin, the requester not granted last wins a tie.
module rom_rr_arbiter
  import rom_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);
`ifdef ROM_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt = 2'b00;
    if (req[0])      gnt = 2'b01;
    else if (req[1]) gnt = 2'b10;
  end
`else
  // Reset to LOAD so FETCH takes the first tie.
  logic last;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       last <= REQ_LOAD;
    else if (accept) last <= gnt[1];
  end

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == REQ_LOAD) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end
`endif
endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one combinational ROM between a fetch (0) and a load (1) requester.
//   clk_i, rst_i - clock, async active-high reset
//   bus          - rom_arbiter_if.slave request/response handshakes
//   rom_addr_o   - ROM address, holds the last accepted address
//   rom_data_i   - combinational ROM read data
//   busy_o       - high whenever a transaction is in flight
// One transaction at a time: IDLE (accept) -> ACCESS (capture ROM) -> RESP (wait ready).
// Response valid two cycles after acceptance; addresses >= WORDS return data 0, err 1.
// Macro ROM_ARB_FIXED_PRIO_EN (in rom_rr_arbiter) selects fixed priority instead of round-robin.
module rom_arbiter
  import rom_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int WORDS      = WORDS_DEF
)(
  input  logic                  clk_i,
  input  logic                  rst_i,
  rom_arbiter_if.slave          bus,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic                  busy_o
);
  state_t                state, state_nx;
  logic                  id;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;
  logic [1:0]            arb_req, gnt;
  logic                  accept;
  logic                  oor;

  // Requests are only visible to the arbiter in IDLE and outside reset,
  // so req_ready_o stays low in every other case.
  assign arb_req = (state == IDLE && !rst_i) ? bus.req_valid_i : 2'b00;
  assign accept  = |gnt;

  rom_rr_arbiter u_arb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req    (arb_req),
    .accept (accept),
    .gnt    (gnt)
  );

  assign oor = ({{(32-ADDR_WIDTH){1'b0}}, rom_addr_o} >= 32'(WORDS));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      id         <= REQ_FETCH;
      rom_addr_o <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        id         <= gnt[1];
        rom_addr_o <= bus.req_addr_i[gnt[1]];
      end
      // Data is captured once; it stays stable for the whole RESP wait.
      if (state == ACCESS) begin
        err_q  <= oor;
        data_q <= oor ? '0 : rom_data_i;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    if (bus.rsp_ready_i[id]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.req_ready_o = gnt;
  assign bus.rsp_valid_o = (state == RESP) ? (id ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_data_o  = data_q;
  assign bus.rsp_err_o   = err_q;
  assign busy_o          = (state != IDLE);
endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the ROM word width.
REQ-002 Parameter ADDR_WIDTH, default 8, SHALL set the ROM address width.
REQ-003 Parameter WORDS, default 5, SHALL set the number of valid ROM words.
REQ-004 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 req_valid_i  input  2  SHALL carry the per-requester request valid (bit 0 fetch, bit 1 load).
REQ-007 req_addr_i  input  2xADDR_WIDTH  SHALL carry the per-requester word address.
REQ-008 req_ready_o  output  2  SHALL signal request acceptance per requester.
REQ-009 rsp_valid_o  output  2  SHALL signal a pending response per requester.
REQ-010 rsp_data_o  output  DATA_WIDTH  SHALL carry the response word, shared by both requesters.
REQ-011 rsp_err_o  output  1  SHALL flag an out-of-range address in the current response.
REQ-012 rsp_ready_i  input  2  SHALL carry the per-requester response acceptance.
REQ-013 rom_addr_o  output  ADDR_WIDTH  SHALL drive the ROM address.
REQ-014 rom_data_i  input  DATA_WIDTH  SHALL receive the combinational ROM data.
REQ-015 busy_o  output  1  SHALL be high whenever the FSM is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-017 In IDLE, req_ready_o SHALL be high only for the arbitration winner among asserted req_valid_i bits; the request is accepted in that cycle.
REQ-018 On acceptance: latch address and winner id, set rom_addr_o to the address, go to ACCESS.
REQ-019 In ACCESS, req_ready_o SHALL be 0; rom_data_i is captured into the response register (0 if out of range); go to RESP.
REQ-020 In RESP, rsp_valid_o[id] SHALL be held high with stable data/err until rsp_ready_i[id]; on that handshake return to IDLE.
REQ-021 Latency: acceptance in cycle T SHALL give rsp_valid_o in cycle T+2; maximum throughput is one request per 3 cycles.
REQ-022 Address >= WORDS SHALL produce rsp_err_o=1 and rsp_data_o=0 with unchanged latency.
REQ-023 Round-robin: on simultaneous requests, the requester not granted last SHALL win; a single requester always wins.
REQ-024 rsp_ready_i for the non-owning requester, and req_valid_i outside IDLE, SHALL be ignored.
REQ-025 rom_addr_o SHALL hold the last accepted address between transactions.

Reset
REQ-026 While rst_i is high: FSM=IDLE, req_ready_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, rom_addr_o=0, busy_o=0, last-grant=1 so requester 0 wins first.
REQ-027 Reset during ACCESS or RESP SHALL drop the transaction with no response.

Configuration
REQ-028 With ROM_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win ties; undefined, round-robin per REQ-023 applies.

Structure
REQ-029 Package rom_pkg SHALL hold the FSM state enum, requester-id constants (REQ_FETCH=0, REQ_LOAD=1) and default width parameters.
REQ-030 The arbitration decision SHALL be placed in sub-module rom_rr_arbiter (2-way, last-grant register inside).

Verification
REQ-031 Single fetch addr 0x02 at T -> req_ready_o=01 at T, rom_addr_o=0x02, rsp_valid_o=01 at T+2, err=0.
REQ-032 Both request continuously after reset -> grants alternate 0,1,0,1 (fixed 0,0,0 with ROM_ARB_FIXED_PRIO_EN).
REQ-033 Load addr 0x05 with WORDS=5 -> rsp_valid_o=10, rsp_err_o=1, rsp_data_o=0.
REQ-034 rsp_ready_i held 0 for 4 cycles -> rsp_valid_o and data stable, no new acceptance, busy_o=1.
REQ-035 rst_i asserted in ACCESS -> all outputs 0 next sample, no response issued, next grant to requester 0.
